serial_adder_arbiter: RTL

Shares a single bit-serial adder between two requesters. Each requester presents a pair of WIDTH-bit operands with a valid/ready handshake. The block grants one requester round-robin and adds the operands LSB-first, one bit per cycle, through a 1-bit full adder built from two half adders. It then returns the (WIDTH+1)-bit sum tagged with the requester ID. It sits between the user-input decode logic and the output pin driver in the adder demo datapath.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/full_adder_bit.sv | 18 +
 rtl/serial_adder_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder arbiter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder composed of two half-adder stages.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1;
  logic c1;

  assign s1   = a ^ b;
  assign c1   = a & b;
  assign sum  = s1 ^ cin;
  assign cout = c1 | (s1 & cin);

endmodule

// File: rtl/serial_adder_arbiter.sv
// Round-robin arbiter feeding a shared LSB-first bit-serial adder.
//   state | meaning
//   IDLE  | arbitrate, accept one operand pair
//   ADD   | one sum bit per cycle, WIDTH cycles
//   DONE  | result valid, wait for res_ready
module serial_adder_arbiter
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sum,
  output logic             res_id,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_gnt_q, last_gnt_d;
  logic [WIDTH:0]   res_sum_q, res_sum_d;
  logic             res_id_q, res_id_d;

  logic [1:0] gnt;
  logic       fa_sum;
  logic       fa_cout;

  full_adder_bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Grant is gated by rst so nothing looks accepted during a reset cycle.
  always_comb begin
    gnt = 2'b00;
    if (state_q == IDLE && !rst) begin
      case (req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    res_sum_d  = res_sum_q;
    res_id_d   = res_id_q;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          owner_d    = gnt[1] ? REQ1 : REQ0;
          last_gnt_d = gnt[1] ? REQ1 : REQ0;
          a_d        = gnt[1] ? req_a1 : req_a0;
          b_d        = gnt[1] ? req_b1 : req_b0;
          carry_d    = 1'b0;
          cnt_d      = '0;
          state_d    = ADD;
        end
      end
      ADD: begin
        carry_d = fa_cout;
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          res_sum_d = {fa_cout, fa_sum, sum_q[WIDTH-1:1]};
          res_id_d  = owner_q;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      owner_q    <= REQ0;
      last_gnt_q <= REQ1;
      res_sum_q  <= '0;
      res_id_q   <= REQ0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      res_sum_q  <= res_sum_d;
      res_id_q   <= res_id_d;
    end
  end

  assign req_ready = gnt;
  assign res_valid = (state_q == DONE);
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);

endmodule
